// File: rtl/uart_baud_ctrl.sv
// Shared baud-tick scheduler for the UART RX/TX channels.
// One programmable divisor; independent per-channel tick phases.
module uart_baud_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 27,
  parameter int B_TICK      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             rx_en,
  output logic             rx_tick,
  input  logic             tx_en,
  output logic             tx_tick,
  output logic [DIV_W-1:0] active_div,
  output logic             cfg_pending,
  output logic             busy
);

  localparam int OS_W = (B_TICK > 1) ? $clog2(B_TICK) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(B_TICK - 1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] div_clamp;
  logic [DIV_W-1:0] rx_cnt;
  logic [DIV_W-1:0] tx_cnt;
  logic [OS_W-1:0]  tx_os;
  logic             rx_wrap;
  logic             tx_wrap;
  logic             idle;

  // Handshake, status and tick decode
  always_comb begin
    busy      = rx_en | tx_en;
    idle      = ~busy;
    cfg_ready = ~cfg_pending;
    div_last  = active_div - DIV_W'(1);
    div_clamp = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
    rx_wrap   = (rx_cnt == div_last);
    tx_wrap   = (tx_cnt == div_last);
    rx_tick   = rx_en & rx_wrap;
    tx_tick   = tx_en & tx_wrap & (tx_os == OS_LAST);
  end

  // Divisor capture; new value only lands while both channels are idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_div  <= DIV_W'(DEFAULT_DIV);
      pend_div    <= DIV_W'(DEFAULT_DIV);
      cfg_pending <= 1'b0;
    end else if (cfg_pending & idle) begin
      active_div  <= pend_div;
      cfg_pending <= 1'b0;
    end else if (cfg_valid & cfg_ready) begin
      pend_div    <= div_clamp;
      cfg_pending <= 1'b1;
    end
  end

  // RX oversample prescaler, phase restarts on every enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt <= '0;
    end else if (!rx_en) begin
      rx_cnt <= '0;
    end else begin
      rx_cnt <= rx_wrap ? '0 : rx_cnt + DIV_W'(1);
    end
  end

  // TX prescaler plus oversample counter giving one tick per bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt <= '0;
      tx_os  <= '0;
    end else if (!tx_en) begin
      tx_cnt <= '0;
      tx_os  <= '0;
    end else begin
      tx_cnt <= tx_wrap ? '0 : tx_cnt + DIV_W'(1);
      if (tx_wrap) begin
        tx_os <= (tx_os == OS_LAST) ? '0 : tx_os + OS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl.
// Expected tick cycles are queued up front and popped on DUT ticks.
module tb_uart_baud_ctrl;

  localparam int DW = 16;
  localparam int DD = 4;
  localparam int BT = 4;

  logic          clk;
  logic          rst;
  logic          cfg_valid;
  logic [DW-1:0] cfg_div;
  logic          cfg_ready;
  logic          rx_en;
  logic          rx_tick;
  logic          tx_en;
  logic          tx_tick;
  logic [DW-1:0] active_div;
  logic          cfg_pending;
  logic          busy;

  int ncmp;
  int nerr;
  int qrx[$];
  int qtx[$];

  uart_baud_ctrl #(
    .DIV_W(DW),
    .DEFAULT_DIV(DD),
    .B_TICK(BT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .rx_en(rx_en),
    .rx_tick(rx_tick),
    .tx_en(tx_en),
    .tx_tick(tx_tick),
    .active_div(active_div),
    .cfg_pending(cfg_pending),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rx_en = 1'b0;
    tx_en = 1'b0;
    cfg_valid = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic run_seq(input int n, input bit rx_on, input int gap,
                         input bit tx_on, input int div);
    int rr;
    int tr;
    bit re;
    rr = 0;
    tr = 0;
    qrx.delete();
    qtx.delete();
    for (int c = 0; c < n; c++) begin
      re = rx_on && (c != gap);
      if (re) begin
        rr++;
        if (rr % div == 0) qrx.push_back(c);
      end else begin
        rr = 0;
      end
      if (tx_on) begin
        tr++;
        if (tr % (div * BT) == 0) qtx.push_back(c);
      end
    end
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rx_en = rx_on && (c != gap);
      tx_en = tx_on;
      @(negedge clk);
      if (rx_tick) begin
        if (qrx.size() > 0) chk("rx_tick_cyc", c, qrx.pop_front());
        else chk("rx_tick_extra", c, 32'hFFFF_FFFF);
      end
      if (tx_tick) begin
        if (qtx.size() > 0) chk("tx_tick_cyc", c, qtx.pop_front());
        else chk("tx_tick_extra", c, 32'hFFFF_FFFF);
      end
    end
    chk("rx_missed", qrx.size(), 0);
    chk("tx_missed", qtx.size(), 0);
    @(posedge clk);
    #1;
    rx_en = 1'b0;
    tx_en = 1'b0;
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst = 1'b0;
    rx_en = 1'b0;
    tx_en = 1'b0;
    cfg_valid = 1'b0;
    cfg_div = '0;
    #22;
    chk("rst_div", active_div, DD);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_pend", cfg_pending, 0);
    chk("rst_rxt", rx_tick, 0);
    chk("rst_txt", tx_tick, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    // RX ticks at 3,7,11
    run_seq(12, 1'b1, -1, 1'b0, DD);
    chk("div_after_rx", active_div, DD);
    chk("ready_after_rx", cfg_ready, 1);

    // RX drop for one cycle at 6: ticks at 3 and 10
    run_seq(12, 1'b1, 6, 1'b0, DD);

    // TX alone: ticks 15,31, no rx ticks
    run_seq(36, 1'b0, -1, 1'b1, DD);

    // Config while idle
    cfg_valid = 1'b1;
    cfg_div = 16'd10;
    @(negedge clk);
    chk("cfg_ready_pre", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chk("cfg_pend_n", cfg_pending, 1);
    chk("cfg_ready_n", cfg_ready, 0);
    chk("cfg_div_n", active_div, DD);
    @(posedge clk);
    #1;
    chk("cfg_div_n1", active_div, 10);
    chk("cfg_pend_n1", cfg_pending, 0);
    chk("cfg_ready_n1", cfg_ready, 1);
    run_seq(25, 1'b1, -1, 1'b0, 10);

    // Clamp and deferred apply while RX busy
    do_reset();
    @(posedge clk);
    #1;
    rx_en = 1'b1;
    cfg_valid = 1'b1;
    cfg_div = 16'd1;
    @(posedge clk);
    #1;
    cfg_div = 16'd8;
    chk("busy_pend", cfg_pending, 1);
    chk("busy_div0", active_div, DD);
    chk("busy_flag", busy, 1);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    chk("busy_div5", active_div, DD);
    chk("busy_ready", cfg_ready, 0);
    rx_en = 1'b0;
    @(posedge clk);
    #1;
    chk("clamp_div", active_div, 2);
    chk("clamp_ready", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chk("second_pend", cfg_pending, 1);
    chk("second_div0", active_div, 2);
    @(posedge clk);
    #1;
    chk("second_div", active_div, 8);

    // Reset mid-frame with divisor pending
    do_reset();
    @(posedge clk);
    #1;
    tx_en = 1'b1;
    cfg_valid = 1'b1;
    cfg_div = 16'd6;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    for (int i = 1; i < 15; i++) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_pend", cfg_pending, 1);
    chk("pre_rst_tick", tx_tick, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_txt", tx_tick, 0);
    chk("arst_rxt", rx_tick, 0);
    chk("arst_pend", cfg_pending, 0);
    chk("arst_div", active_div, DD);
    tx_en = 1'b0;
    #1;
    rst = 1'b1;
    run_seq(20, 1'b0, -1, 1'b1, DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
